// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch-stage PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_e;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: pipeline/imem-facing signals of the PC sequencer
interface pc_sequencer_if #(parameter int XLEN = 64, parameter int CNT_W = 32);
  logic stall, br_taken, trap_valid, halt, imem_ready;
  logic [XLEN-1:0] br_target, trap_target, pc_next, pc_cur;
  logic imem_req, fetch_valid, flush, halted;
  logic [CNT_W-1:0] fetch_count;
  modport master (
    input stall, br_taken, br_target, trap_valid, trap_target, halt, imem_ready,
    output pc_next, pc_cur, imem_req, fetch_valid, flush, halted, fetch_count
  );
  modport slave (
    output stall, br_taken, br_target, trap_valid, trap_target, halt, imem_ready,
    input pc_next, pc_cur, imem_req, fetch_valid, flush, halted, fetch_count
  );
endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds a redirect target that arrived while imem was stalled
module pc_redirect_buf #(parameter int XLEN = 64) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_i,
  input  logic [XLEN-1:0] tgt_i,
  input  logic            clr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] tgt_o
);
  logic            valid_q;
  logic [XLEN-1:0] tgt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tgt_q   <= '0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      tgt_q   <= tgt_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end
  assign valid_o = valid_q;
  assign tgt_o   = tgt_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC selection (sequential/redirect/trap/hold) and imem request control
module pc_sequencer import pc_seq_pkg::*; #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              CNT_W        = 32
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.master bus
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, raw_tgt, redir_tgt, pend_tgt;
  logic [CNT_W-1:0] cnt_q;
  logic            fetch, redir, pend_v, acc;
  assign fetch     = state_q == FETCH;
  assign redir     = fetch & (bus.trap_valid | bus.br_taken);
  assign raw_tgt   = bus.trap_valid ? bus.trap_target : bus.br_target;
  assign redir_tgt = {raw_tgt[XLEN-1:2], 2'b00};
  assign acc       = fetch & bus.imem_ready & ~redir & ~pend_v & ~bus.stall;
  pc_redirect_buf #(.XLEN(XLEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (redir & ~bus.imem_ready),
    .tgt_i   (redir_tgt),
    .clr_i   (fetch & bus.imem_ready),
    .valid_o (pend_v),
    .tgt_o   (pend_tgt)
  );
  // A trap arriving with halt must land in pc_cur even if imem is still waiting
  always_comb begin
    pc_d = rst                                  ? RESET_VECTOR :
           (fetch & bus.halt & bus.trap_valid)  ? redir_tgt    :
           (~fetch | ~bus.imem_ready)           ? pc_q         :
           redir                                ? redir_tgt    :
           pend_v                               ? pend_tgt     :
           bus.stall                            ? pc_q         :
                                                  pc_q + XLEN'(INSTR_BYTES);
    state_d = (state_q == BOOT)   ? FETCH :
              (fetch & bus.halt)  ? HALT  : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (acc) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.pc_next     = pc_d;
  assign bus.pc_cur      = pc_q;
  assign bus.imem_req    = fetch;
  assign bus.fetch_valid = acc & ~rst;
  assign bus.flush       = redir & ~rst;
  assign bus.halted      = state_q == HALT;
  assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer with hand-derived per-cycle expectations
module tb_pc_sequencer;
  typedef struct {
    string       tag;
    logic [63:0] pc_cur, pc_next;
    logic        fv, fl, req, hlt;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0, n_err = 0;
  exp_t sb[$];
  pc_sequencer_if #(.XLEN(64), .CNT_W(32)) bus();
  pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set(input logic s, input logic b, input logic [63:0] bt, input logic t,
                     input logic [63:0] tt, input logic h, input logic r);
    bus.stall = s; bus.br_taken = b; bus.br_target = bt;
    bus.trap_valid = t; bus.trap_target = tt; bus.halt = h; bus.imem_ready = r;
  endtask
  task automatic want(input string tag, input logic [63:0] pcc, input logic [63:0] pcn,
                      input logic fv, input logic fl, input logic req, input logic hlt, input logic [31:0] cnt);
    exp_t e;
    sb.push_back('{tag, pcc, pcn, fv, fl, req, hlt, cnt});
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".pc_cur"}, bus.pc_cur, e.pc_cur);
    check({e.tag, ".pc_next"}, bus.pc_next, e.pc_next);
    check({e.tag, ".fetch_valid"}, 64'(bus.fetch_valid), 64'(e.fv));
    check({e.tag, ".flush"}, 64'(bus.flush), 64'(e.fl));
    check({e.tag, ".imem_req"}, 64'(bus.imem_req), 64'(e.req));
    check({e.tag, ".halted"}, 64'(bus.halted), 64'(e.hlt));
    check({e.tag, ".fetch_count"}, 64'(bus.fetch_count), 64'(e.cnt));
    @(posedge clk);
    #1;
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    want("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    want("boot", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) want("seq", 64'(4 * i), 64'(4 * i + 4), 1, 0, 1, 0, 32'(i));
    set(1, 0, 0, 0, 0, 0, 1);
    want("stall1", 64'h10, 64'h10, 0, 0, 1, 0, 4);
    want("stall2", 64'h10, 64'h10, 0, 0, 1, 0, 4);
    set(0, 0, 0, 0, 0, 0, 1);
    want("resume", 64'h10, 64'h14, 1, 0, 1, 0, 4);
    set(1, 1, 64'h103, 1, 64'h200, 0, 1);
    want("trap_over_br", 64'h14, 64'h200, 0, 1, 1, 0, 5);
    set(0, 0, 0, 0, 0, 0, 1);
    want("post_trap", 64'h200, 64'h204, 1, 0, 1, 0, 5);
    set(0, 1, 64'h103, 0, 0, 0, 1);
    want("br_align", 64'h204, 64'h100, 0, 1, 1, 0, 6);
    set(0, 0, 0, 0, 0, 0, 1);
    want("post_br", 64'h100, 64'h104, 1, 0, 1, 0, 6);
    set(0, 1, 64'h80, 0, 0, 0, 0);
    want("wait_br", 64'h104, 64'h104, 0, 1, 1, 0, 7);
    set(0, 0, 0, 0, 0, 0, 0);
    want("wait2", 64'h104, 64'h104, 0, 0, 1, 0, 7);
    want("wait3", 64'h104, 64'h104, 0, 0, 1, 0, 7);
    set(0, 0, 0, 0, 0, 0, 1);
    want("pend_use", 64'h104, 64'h80, 0, 0, 1, 0, 7);
    want("post_pend", 64'h80, 64'h84, 1, 0, 1, 0, 7);
    set(0, 1, 64'h300, 0, 0, 0, 0);
    want("pend_br", 64'h84, 64'h84, 0, 1, 1, 0, 8);
    set(0, 0, 0, 1, 64'h400, 0, 0);
    want("pend_trap", 64'h84, 64'h84, 0, 1, 1, 0, 8);
    set(0, 0, 0, 0, 0, 0, 1);
    want("pend_trap_use", 64'h84, 64'h400, 0, 0, 1, 0, 8);
    want("post_pend_trap", 64'h400, 64'h404, 1, 0, 1, 0, 8);
    set(0, 1, 64'h600, 0, 0, 0, 0);
    want("pend_old", 64'h404, 64'h404, 0, 1, 1, 0, 9);
    set(0, 1, 64'h700, 0, 0, 0, 1);
    want("new_wins", 64'h404, 64'h700, 0, 1, 1, 0, 9);
    set(0, 0, 0, 0, 0, 0, 1);
    want("pend_cleared", 64'h700, 64'h704, 1, 0, 1, 0, 9);
    set(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1);
    want("to_top", 64'h704, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 0, 10);
    set(0, 0, 0, 0, 0, 0, 1);
    want("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 0, 1, 0, 10);
    want("post_wrap", 64'h0, 64'h4, 1, 0, 1, 0, 11);
    set(0, 1, 64'h40, 0, 0, 0, 1);
    want("to_40", 64'h4, 64'h40, 0, 1, 1, 0, 12);
    set(0, 0, 0, 0, 0, 1, 0);
    want("halt_req", 64'h40, 64'h40, 0, 0, 1, 0, 12);
    set(0, 1, 64'h900, 0, 0, 0, 1);
    want("halted_br", 64'h40, 64'h40, 0, 0, 0, 1, 12);
    set(1, 0, 0, 1, 64'hA00, 0, 1);
    want("halted_trap", 64'h40, 64'h40, 0, 0, 0, 1, 12);
    set(0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    want("rst_in_halt", 64'h40, 64'h0, 0, 0, 0, 1, 12);
    rst = 1'b0;
    want("reboot", 0, 0, 0, 0, 0, 0, 0);
    want("refetch", 0, 4, 1, 0, 1, 0, 0);
    set(0, 0, 0, 1, 64'h123, 1, 0);
    want("halt_trap", 64'h4, 64'h120, 0, 1, 1, 0, 1);
    set(0, 0, 0, 0, 0, 0, 1);
    want("halt_at_trap", 64'h120, 64'h120, 0, 0, 0, 1, 1);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
